imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_pkg.sv | 26 ++
 rtl/imem_responder_line_buf.sv | 59 +++++
 rtl/imem_responder.sv | 153 +++++++++++++++
 tb/tb_imem_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-side memory responder:
// FSM state encoding, line geometry and the pipeline NOP word.
package imem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL_REQ  = 2'd1,
        FILL_WAIT = 2'd2,
        RESP      = 2'd3
    } state_e;

    localparam int LINE_WORDS = 4;
    localparam int IDX_W      = $clog2(LINE_WORDS);
    localparam int TAG_W      = 16 - IDX_W - 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    // Instruction word the fetch stage injects when it has nothing to issue.
    localparam logic [15:0] NOP_WORD = 16'h0800;

    // Line tag of a byte address (everything above word index and byte bit).
    function automatic logic [TAG_W-1:0] tag_of(input logic [15:0] addr);
        return addr[15:IDX_W+1];
    endfunction

endpackage

// File: rtl/imem_responder_line_buf.sv
// Single-line instruction buffer: four 16-bit words, one tag, one valid bit.
// Word storage and tag are plain data registers; only the valid bit is reset.
module imem_responder_line_buf
    import imem_responder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tag_we_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             set_valid_i,
    input  logic             clr_valid_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [15:0]      wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [15:0]      rdata_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             valid_o
);

    logic [15:0]      words_q [LINE_WORDS];
    logic [TAG_W-1:0] tag_q;
    logic             valid_q;
    logic             valid_d;

    // Clearing wins over setting so an invalidate is never lost.
    always_comb begin
        valid_d = valid_q;
        if (clr_valid_i) begin
            valid_d = 1'b0;
        end else if (set_valid_i) begin
            valid_d = 1'b1;
        end
    end

    // Word storage and tag capture; contents are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            words_q[widx_i] <= wdata_i;
        end
        if (tag_we_i) begin
            tag_q <= tag_i;
        end
    end

    // Valid bit, dropped asynchronously so an abandoned fill is never used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign rdata_o = words_q[ridx_i];
    assign tag_o   = tag_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: serves hits from a one-line buffer in the
// request cycle, otherwise fills the whole line word by word (0..3) from the
// backing store and answers with the requested word.
module imem_responder
    import imem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        inv,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] bk_addr,
    output logic        bk_rd,
    input  logic [15:0] bk_data,
    input  logic        bk_valid
);

    state_e           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             inv_seen_q;

    logic [15:0]      lb_rdata;
    logic [TAG_W-1:0] lb_tag;
    logic             lb_valid;
    logic [IDX_W-1:0] lb_ridx;
    logic             lb_tag_we;
    logic             lb_we;
    logic             lb_set;
    logic             lb_clr;

    logic             req_err;
    logic             req_ok;
    logic             hit;
    logic             miss;

    // Request classification and line-buffer control.
    always_comb begin
        req_err   = Rd & (Addr[0] | Wr);
        req_ok    = Rd & ~Addr[0] & ~Wr;
        hit       = req_ok & lb_valid & (lb_tag == tag_of(Addr));
        miss      = req_ok & ~hit;
        lb_tag_we = (state_q == IDLE) & miss;
        lb_clr    = (state_q == IDLE) & (miss | inv);
        lb_set    = (state_q == RESP) & ~inv_seen_q & ~inv;
        lb_we     = (state_q == FILL_WAIT) & bk_valid;
        lb_ridx   = (state_q == RESP) ? idx_q : Addr[IDX_W:1];
    end

    imem_responder_line_buf u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .tag_we_i    (lb_tag_we),
        .tag_i       (tag_of(Addr)),
        .set_valid_i (lb_set),
        .clr_valid_i (lb_clr),
        .we_i        (lb_we),
        .widx_i      (cnt_q),
        .wdata_i     (bk_data),
        .ridx_i      (lb_ridx),
        .rdata_o     (lb_rdata),
        .tag_o       (lb_tag),
        .valid_o     (lb_valid)
    );

    // Fill sequencing: one backing-store word per FILL_REQ/FILL_WAIT pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            inv_seen_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        idx_q      <= Addr[IDX_W:1];
                        cnt_q      <= '0;
                        inv_seen_q <= 1'b0;
                        state_q    <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (inv) inv_seen_q <= 1'b1;
                    state_q <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (inv) inv_seen_q <= 1'b1;
                    if (bk_valid) begin
                        if (cnt_q == LAST_IDX) begin
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= FILL_REQ;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Response and backing-store strobes; hits and errors answer in the
    // request cycle, so these follow the inputs and are forced low in reset.
    always_comb begin
        Done     = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        Stall    = 1'b0;
        bk_rd    = 1'b0;
        DataOut  = 16'h0000;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (req_err) begin
                        Done = 1'b1;
                        err  = 1'b1;
                    end else if (hit) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        DataOut  = lb_rdata;
                    end else if (miss) begin
                        Stall = 1'b1;
                    end
                end
                FILL_REQ: begin
                    Stall = 1'b1;
                    bk_rd = 1'b1;
                end
                FILL_WAIT: begin
                    Stall = 1'b1;
                end
                RESP: begin
                    Done    = 1'b1;
                    DataOut = lb_rdata;
                end
                default: ;
            endcase
        end
    end

    assign bk_addr = {lb_tag, cnt_q, 1'b0};

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: a request driver predicts responses
// and backing-store addresses from a one-line cache model, a monitor checks
// every Done and bk_rd, and a backing-store model answers with random latency.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic [15:0] Addr;
    logic        Rd;
    logic        Wr;
    logic        inv;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;
    logic [15:0] bk_addr;
    logic        bk_rd;
    logic [15:0] bk_data;
    logic        bk_valid;

    imem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .Addr     (Addr),
        .Rd       (Rd),
        .Wr       (Wr),
        .inv      (inv),
        .DataOut  (DataOut),
        .Done     (Done),
        .Stall    (Stall),
        .CacheHit (CacheHit),
        .err      (err),
        .bk_addr  (bk_addr),
        .bk_rd    (bk_rd),
        .bk_data  (bk_data),
        .bk_valid (bk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        hit;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    logic [15:0] bk_exp[$];

    int n_cmp = 0;
    int n_bad = 0;
    int bk_rd_seen = 0;
    int lat_min = 1;
    int lat_max = 1;

    // Reference model of the line: valid, tag and the four words it holds.
    bit          m_valid = 1'b0;
    logic [12:0] m_tag;
    logic [15:0] m_words [4];
    logic [15:0] lines [4];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [31:0] p;
        p = a * 32'h9E37;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Backing store: answers each bk_rd after a random latency of >=1 cycle.
    bit          bs_busy = 1'b0;
    int          bs_cnt  = 0;
    logic [15:0] bs_addr;
    initial begin
        forever begin
            @(negedge clk);
            bk_valid = 1'b0;
            bk_data  = imem_responder_pkg::NOP_WORD;
            if (bs_busy) begin
                bs_cnt--;
                if (bs_cnt == 0) begin
                    bk_valid = 1'b1;
                    bk_data  = mem_word(bs_addr);
                    bs_busy  = 1'b0;
                end
            end
            if (bk_rd && !rst) begin
                bs_addr = bk_addr;
                bs_cnt  = $urandom_range(lat_max, lat_min);
                bs_busy = 1'b1;
            end
        end
    end

    // Monitor: checks every response and every backing-store read.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (Done) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check("resp{data,hit,err,stall}", {DataOut, CacheHit, err, Stall},
                          {e.data, e.hit, e.err, 1'b0});
                end
            end else begin
                check("qualifiers_low", {CacheHit, err}, 2'b00);
            end
            if (bk_rd) begin
                bk_rd_seen++;
                if (bk_exp.size() == 0) fail_now("unexpected_bk_rd");
                else check("bk_addr", bk_addr, bk_exp.pop_front());
            end
        end
    end

    // Issue one fetch request, predict its outcome, hold it until Done.
    task automatic issue(input logic [15:0] a, input bit w, input int inv_k, input bit inv_same);
        bit          is_err;
        bit          is_hit;
        logic [15:0] base;
        resp_t       r;
        int          cyc;
        bit          done_seen;
        @(negedge clk);
        Addr = a;
        Wr   = w;
        Rd   = 1'b1;
        inv  = inv_same;
        is_err = a[0] | w;
        is_hit = !is_err && m_valid && (m_tag == a[15:3]);
        base   = {a[15:3], 3'b000};
        if (is_err) begin
            r = '{data: 16'h0000, hit: 1'b0, err: 1'b1};
            if (inv_same) m_valid = 1'b0;
        end else if (is_hit) begin
            r = '{data: m_words[a[2:1]], hit: 1'b1, err: 1'b0};
            if (inv_same) m_valid = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                bk_exp.push_back(16'(base + 2 * i));
                m_words[i] = mem_word(16'(base + 2 * i));
            end
            m_tag   = a[15:3];
            m_valid = (inv_k == 0);
            r = '{data: m_words[a[2:1]], hit: 1'b0, err: 1'b0};
        end
        exp_q.push_back(r);
        #2;
        check("stall_on_issue", Stall, !is_err && !is_hit);
        done_seen = Done;
        cyc = 0;
        while (!done_seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            inv = (inv_k > 0) && (cyc == inv_k);
            #2;
            done_seen = Done;
        end
        if (!done_seen) fail_now("done_timeout");
    endtask

    // Idle cycles with Rd low, optionally pulsing invalidate in the first.
    task automatic gap(input int n, input bit do_inv);
        @(negedge clk);
        Rd   = 1'b0;
        Wr   = 1'b0;
        inv  = do_inv;
        Addr = 16'($urandom);
        #2;
        check("idle_outputs", {Done, Stall, CacheHit, err, DataOut, bk_rd}, '0);
        if (do_inv) m_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            inv = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          cyc;
        int          start;
        int          r;
        logic [15:0] a;
        bit          w;
        bit          hit_pred;
        bit          inv_same;
        int          inv_k;

        lines[0] = 16'h0100;
        lines[1] = 16'h0108;
        lines[2] = 16'h0200;
        lines[3] = 16'hFFF8;

        rst      = 1'b1;
        Rd       = 1'b0;
        Wr       = 1'b0;
        inv      = 1'b0;
        Addr     = 16'h0000;
        bk_valid = 1'b0;
        bk_data  = imem_responder_pkg::NOP_WORD;
        #1;
        check("reset_outputs", {Done, Stall, CacheHit, err, DataOut, bk_rd}, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        gap(1, 1'b0);

        // Cold miss with latency 2, then a hit in the same line.
        lat_min = 2;
        lat_max = 2;
        issue(16'h0104, 1'b0, 0, 1'b0);
        issue(16'h0106, 1'b0, 0, 1'b0);

        // Misaligned and write requests are rejected without a fill.
        issue(16'h0105, 1'b0, 0, 1'b0);
        issue(16'h0100, 1'b1, 0, 1'b0);
        issue(16'h0100, 1'b0, 0, 1'b0);

        // Invalidate during a fill: response delivered, line left invalid.
        lat_min = 1;
        lat_max = 3;
        issue(16'h0200, 1'b0, 3, 1'b0);
        issue(16'h0202, 1'b0, 0, 1'b0);

        // Same-cycle invalidate still serves the hit, next access misses.
        issue(16'h0204, 1'b0, 0, 1'b1);
        issue(16'h0206, 1'b0, 0, 1'b0);

        // Reset in FILL_WAIT after two words; stray bk_valid must be ignored.
        gap(1, 1'b1);
        lat_min = 4;
        lat_max = 4;
        @(negedge clk);
        Addr = 16'h0100;
        Wr   = 1'b0;
        Rd   = 1'b1;
        for (int i = 0; i < 4; i++) bk_exp.push_back(16'(16'h0100 + 2 * i));
        start = bk_rd_seen;
        cyc   = 0;
        while (bk_rd_seen < start + 3 && cyc < 200) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check("third_bk_rd_seen", bk_rd_seen - start, 3);
        @(negedge clk);
        rst = 1'b1;
        Rd  = 1'b0;
        #2;
        check("reset_midfill_outputs", {Done, Stall, CacheHit, err, DataOut, bk_rd}, '0);
        check("reset_midfill_pending_bk", bk_exp.size(), 1);
        bk_exp.delete();
        m_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        lat_min = 1;
        lat_max = 2;
        issue(16'h0100, 1'b0, 0, 1'b0);
        issue(16'h0102, 1'b0, 0, 1'b0);

        // Random traffic over a few lines, including the top of memory.
        for (int n = 0; n < 150; n++) begin
            a = lines[$urandom_range(0, 3)] | {13'b0, 2'($urandom_range(0, 3)), 1'b0};
            r = $urandom_range(0, 99);
            if (r < 8) a[0] = 1'b1;
            w = (r >= 8 && r < 16);
            lat_min = 1;
            lat_max = $urandom_range(1, 4);
            hit_pred = !a[0] && !w && m_valid && (m_tag == a[15:3]);
            inv_same = hit_pred && ($urandom_range(0, 9) == 0);
            inv_k = (!a[0] && !w && !hit_pred && $urandom_range(0, 5) == 0)
                    ? $urandom_range(1, 7) : 0;
            issue(a, w, inv_k, inv_same);
            if ($urandom_range(0, 3) == 0) gap($urandom_range(0, 3), $urandom_range(0, 5) == 0);
        end

        gap(5, 1'b0);
        check("responses_outstanding", exp_q.size(), 0);
        check("bk_reads_outstanding", bk_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
